// File: rtl/sbox_scheduler.sv
// sbox_scheduler
// ---------------------------------------------------------------------------
// Time-shared AES SubBytes engine. A bank of four forward S-box lookups is
// shared between two requesters:
//   - the round datapath (128-bit state, one 32-bit column per cycle), and
//   - the key expander (32-bit SubWord, one cycle).
// Results are registered and announced with a one-cycle done pulse.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   st_valid  in   state job requested
//   st_in     in   128-bit state, byte 0 = st_in[127:120]
//   st_ready  out  state job accepted when st_valid && st_ready
//   st_out    out  substituted state (sample only on st_done)
//   st_done   out  one-cycle pulse, st_out just completed
//   kw_valid  in   key SubWord requested
//   kw_in     in   32-bit word, msbyte first
//   kw_ready  out  key job accepted when kw_valid && kw_ready
//   kw_out    out  substituted word
//   kw_done   out  one-cycle pulse, kw_out just updated
//   busy      out  FSM is not idle
//
// Build option: define SBOX_KEY_PRIORITY_EN to let key jobs win every IDLE
// arbitration and to let a key job be slipped in between two columns of a
// running state job (one KW_INS cycle). Without it, arbitration is strict
// job-level round-robin.

module sbox_scheduler #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  input  logic [127:0] st_in,
  output logic         st_ready,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  input  logic [31:0]  kw_in,
  output logic         kw_ready,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
`ifdef SBOX_KEY_PRIORITY_EN
    , KW_INS = 2'd3
`endif
  } state_e;

  typedef enum logic {
    OWNER_ST = 1'b0,
    OWNER_KW = 1'b1
  } owner_e;

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  // Forward S-box. Entry for input 0x00 sits at index 255, so lookups use ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] subWord(input logic [31:0] w);
    subWord = {SBOX[~w[31:24]], SBOX[~w[23:16]], SBOX[~w[15:8]], SBOX[~w[7:0]]};
  endfunction

  state_e         state_q, state_d;
  owner_e         last_q, last_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   st_q, st_d;
  logic [31:0]    kw_q, kw_d;
  logic [127:0]   st_out_q, st_out_d;
  logic [31:0]    kw_out_q, kw_out_d;
  logic           st_done_q, st_done_d;
  logic           kw_done_q, kw_done_d;
  logic [31:0]    bankIn;
  logic [31:0]    bankOut;

`ifdef SBOX_KEY_PRIORITY_EN
  // Set for the one ST_RUN cycle that follows an insertion, so a column
  // always gets processed between two inserted keys.
  logic           ins_q;

  always_ff @(posedge clk) begin
    if (rst) ins_q <= 1'b0;
    else     ins_q <= (state_q == KW_INS);
  end
`endif

  // Bank input select: the current column while a state job runs, otherwise
  // the key word.
  always_comb begin
    bankIn = kw_q;
    if (state_q == ST_RUN) begin
      case (col_q)
        2'd0: bankIn = st_q[127:96];
        2'd1: bankIn = st_q[95:64];
        2'd2: bankIn = st_q[63:32];
        2'd3: bankIn = st_q[31:0];
      endcase
    end
  end

  assign bankOut = subWord(bankIn);

  // Next-state, arbitration and result write-back.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    col_d     = col_q;
    st_d      = st_q;
    kw_d      = kw_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
    st_ready  = 1'b0;
    kw_ready  = 1'b0;

    case (state_q)
      IDLE: begin
`ifdef SBOX_KEY_PRIORITY_EN
        kw_ready = !rst;
        st_ready = !rst && !kw_valid;
`else
        // Readies never look at their own valid; on a tie the requester
        // that was not served last wins.
        st_ready = !rst && !(kw_valid && last_q == OWNER_ST);
        kw_ready = !rst && !(st_valid && last_q == OWNER_KW);
`endif
        if (st_valid && st_ready) begin
          st_d    = st_in;
          col_d   = 2'd0;
          last_d  = OWNER_ST;
          state_d = ST_RUN;
        end else if (kw_valid && kw_ready) begin
          kw_d    = kw_in;
          last_d  = OWNER_KW;
          state_d = KW_RUN;
        end
      end

      ST_RUN: begin
        case (col_q)
          2'd0: st_out_d[127:96] = bankOut;
          2'd1: st_out_d[95:64]  = bankOut;
          2'd2: st_out_d[63:32]  = bankOut;
          2'd3: st_out_d[31:0]   = bankOut;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == LAST_COL) begin
          st_done_d = 1'b1;
          state_d   = IDLE;
        end
`ifdef SBOX_KEY_PRIORITY_EN
        // No insertion after the final column: col has wrapped by then and
        // there would be no column left to resume.
        else begin
          kw_ready = !rst && !ins_q;
          if (kw_valid && kw_ready) begin
            kw_d    = kw_in;
            last_d  = OWNER_KW;
            state_d = KW_INS;
          end
        end
`endif
      end

      KW_RUN: begin
        kw_out_d  = bankOut;
        kw_done_d = 1'b1;
        state_d   = IDLE;
      end

`ifdef SBOX_KEY_PRIORITY_EN
      KW_INS: begin
        kw_out_d  = bankOut;
        kw_done_d = 1'b1;
        state_d   = ST_RUN;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= OWNER_KW;
      col_q     <= 2'd0;
      st_q      <= '0;
      kw_q      <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      col_q     <= col_d;
      st_q      <= st_d;
      kw_q      <= kw_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
    end
  end

  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/sbox_scheduler.md
# sbox_scheduler

Time-shared SubBytes engine for the AES datapath. It owns a bank of four byte S-box lookups and arbitrates that bank between two requesters: the round datapath, which needs a 128-bit state substituted, and the key expander, which needs a 32-bit SubWord. A state job runs one 32-bit column per cycle over four cycles; a key job takes one cycle. Results are registered and announced with a one-cycle done pulse.

## Interface
Parameters:
- `NCOL`, 4: columns per state job. Fixed at 4; no other value is supported.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `st_valid`  in  1  state job requested.
- `st_in`  in  128  state to substitute. Byte 0 is `st_in[127:120]`. Column c is `st_in[127-32c -: 32]`.
- `st_ready`  out  1  state job accepted on this edge when `st_valid && st_ready`.
- `st_out`  out  128  substituted state, using the same byte order. Holds its value until the next state job completes.
- `st_done`  out  1  one-cycle pulse: `st_out` has just been updated.
- `kw_valid`  in  1  key SubWord requested.
- `kw_in`  in  32  word to substitute, msbyte first.
- `kw_ready`  out  1  key job accepted when `kw_valid && kw_ready`.
- `kw_out`  out  32  substituted word. Holds its value until the next key job completes.
- `kw_done`  out  1  one-cycle pulse: `kw_out` has just been updated.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, ST_RUN, KW_RUN, plus KW_INS when SBOX_KEY_PRIORITY_EN is defined.
- On acceptance, the input is captured into a job register (`st_q` or `kw_q`).
- Each of the four lookup units maps one byte with the standard AES forward S-box, e.g. 00→63, 53→ed, ff→16.
- Round-robin arbitration in IDLE uses a `last` bit (ST or KW). The reset value is KW, so state wins the first tie.
  - `st_ready = IDLE && !(kw_valid && last==ST)`.
  - `kw_ready = IDLE && !(st_valid && last==KW)`.
  - Neither ready depends on its own valid. When both valids are high, exactly one ready is high.
- `last` updates to the granted requester on each acceptance.
- ST_RUN:
  - 2-bit column counter `col` is 0 on entry.
  - Each cycle the bank processes column `col` of `st_q` and writes the result into the same slice of `st_out`. Then `col` increments.
  - When column 3 is written, `st_done` pulses in the next cycle, the FSM returns to IDLE, and `col` wraps to 0.
- KW_RUN: the bank processes `kw_q` and writes `kw_out`. `kw_done` pulses in the next cycle. The FSM returns to IDLE.
- `st_out` slices are written column by column. Consumers must sample `st_out` only on `st_done`.
- All ready outputs are 0 while `rst` is high and in every non-IDLE state, except as stated under Configuration.

## Timing
- Reset values: `st_out`=0, `kw_out`=0, `st_done`=0, `kw_done`=0, `busy`=0, `st_ready`=0, `kw_ready`=0. Internal: FSM=IDLE, `col`=0, `last`=KW.
- State job accepted at edge k:
  - ST_RUN covers cycles k..k+3 (column c written at edge k+1+c).
  - `st_done`=1 in the cycle after edge k+4. Latency is 4 cycles, without key insertion.
- Key job accepted at edge k: `kw_out` is written at edge k+1, and `kw_done`=1 in the cycle after edge k+1.
- Back-to-back jobs: a new job can be accepted in the same cycle its predecessor's done pulse is high (FSM is IDLE then).
  - Sustained throughput: one state job per 5 cycles, one key job per 2 cycles.
  - With both requesters continuously valid, grants alternate ST, KW, ST, ...
- Reset mid-job: the job is discarded, no done pulse is produced, and outputs return to their reset values the next cycle.
- Input changes after acceptance have no effect. Valid deasserted without acceptance is legal (no commitment).

## Configuration
- SBOX_KEY_PRIORITY_EN defined: key jobs get low-latency service.
  - In IDLE, `kw_ready = IDLE && rst==0`: key always wins, and `st_ready = IDLE && !kw_valid`.
  - In ST_RUN, `kw_ready=1` if the previous cycle was not KW_INS.
  - A key accepted in ST_RUN moves the FSM to KW_INS for one cycle. That cycle processes the key word, and `kw_done` follows. The FSM then resumes ST_RUN at the same `col`.
  - Each insertion adds one cycle to that state job (maximum latency 7). At most one insertion occurs between consecutive state columns, so state jobs cannot starve mid-job.
- SBOX_KEY_PRIORITY_EN undefined:
  - Strict job-level round-robin as described above.
  - `kw_ready`=0 outside IDLE.
  - The KW_INS state does not exist.

## Test plan
- Reset, idle: hold `rst` 3 cycles with both valids high → all outputs 0 during reset. After release, st wins the first tie (`st_ready`=1, `kw_ready`=0).
- State job: `st_in`=00112233445566778899aabbccddeeff accepted at edge k → `st_done` after edge k+4 with `st_out`=638293c31bfc33f5c4eeacea4bc12816.
- Key job: `kw_in`=cf4f3c09 → `kw_done` 1 cycle after acceptance, `kw_out`=8a84eb01.
- Contention: both requesters continuously valid for 20 cycles → grants alternate ST, KW, ST, ... and each done pulse is exactly 1 cycle wide.
- Reset mid-job: assert `rst` 2 cycles into a state job → no `st_done`, `st_out`=0. A fresh job afterwards completes correctly.
- SBOX_KEY_PRIORITY_EN: raise `kw_valid` with cf4f3c09 at `col`=1 of the state job above → `kw_out`=8a84eb01 pulses mid-job. `st_done` arrives 5 cycles after state acceptance with an unchanged `st_out` value.
